adder_sum_accumulator: RTL and testbench

//   Downstream consumer of the n-bit ripple-carry adder stage. Accepts one
//   {carry, sum} result per valid/ready handshake and accumulates COUNT

---
 rtl/adder_sum_accumulator.sv | 117 +++++++++++
 tb/tb_adder_sum_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT {carry,sum} adder results per burst and holds the total with a sticky overflow flag until accepted.
// Optional feature macro SATURATE_EN: clamp the total to all ones on overflow instead of wrapping.
module adder_sum_accumulator #(
    parameter int N     = 16,
    parameter int ACC_W = 20,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sum_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     value;
    logic [ACC_W:0]     sum;
    logic               in_xfer;
    logic               out_xfer;
    logic               last;

    // Bit ACC_W of the sum is the overflow bit of the accumulate.
    assign value    = {{(ACC_W - N){1'b0}}, carry_in, sum_in};
    assign sum      = {1'b0, acc_q} + value;
    assign in_ready = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign last     = (cnt_q == CNT_W'(COUNT - 1));
    assign acc_out  = acc_q;
    assign overflow = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        acc_d   = value[ACC_W-1:0];
                        cnt_d   = CNT_W'(1);
                        state_d = (COUNT == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
`ifdef SATURATE_EN
                        // Once clamped, the total stays pinned for the rest of the burst.
                        if (sum[ACC_W] || ovf_q) begin
                            acc_d = '1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        if (last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_xfer) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: a 20-bit and an 18-bit instance share stimulus and are checked
// against an arithmetic burst model plus directed literal expectations.
module tb_adder_sum_accumulator;
    localparam int N     = 16;
    localparam int COUNT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] sum_in;
    logic        carry_in;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [19:0] acc_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [17:0] acc_b;

    int checks = 0;
    int errors = 0;

    longint m_acc [2];
    bit     m_ovf [2];
    int     widths [2] = '{20, 18};

    adder_sum_accumulator #(.N(N), .ACC_W(20), .COUNT(COUNT)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
        .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .acc_out(acc_a), .overflow(ovf_a)
    );

    adder_sum_accumulator #(.N(N), .ACC_W(18), .COUNT(COUNT)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
        .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .acc_out(acc_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    // Burst total rules: add as integers, flag any partial sum reaching 2^W, then wrap or clamp.
    task automatic model_in(input longint v);
        for (int k = 0; k < 2; k++) begin
            longint lim;
            longint s;
            lim = longint'(1) << widths[k];
            s   = m_acc[k] + v;
            if (s >= lim) m_ovf[k] = 1'b1;
`ifdef SATURATE_EN
            if (m_ovf[k]) m_acc[k] = lim - 1;
            else          m_acc[k] = s;
`else
            m_acc[k] = s % lim;
`endif
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [15:0] s, input logic c);
        in_valid = 1'b1;
        sum_in   = s;
        carry_in = c;
        chk("in_ready_at_send", {63'd0, in_ready_a}, 64'd1);
        @(posedge clk);
        model_in(longint'({c, s}));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_total(input string tag);
        chk({tag, "_out_valid_a"}, {63'd0, out_valid_a}, 64'd1);
        chk({tag, "_out_valid_b"}, {63'd0, out_valid_b}, 64'd1);
        chk({tag, "_in_ready"},    {63'd0, in_ready_a},  64'd0);
        chk({tag, "_acc_a"},       {44'd0, acc_a},       64'(m_acc[0]));
        chk({tag, "_ovf_a"},       {63'd0, ovf_a},       {63'd0, m_ovf[0]});
        chk({tag, "_acc_b"},       {46'd0, acc_b},       64'(m_acc[1]));
        chk({tag, "_ovf_b"},       {63'd0, ovf_b},       {63'd0, m_ovf[1]});
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        model_clear();
        chk({tag, "_idle_out_valid"}, {63'd0, out_valid_a}, 64'd0);
        chk({tag, "_idle_in_ready"},  {63'd0, in_ready_a},  64'd1);
        chk({tag, "_idle_acc"},       {44'd0, acc_a},       64'd0);
        chk({tag, "_idle_ovf"},       {63'd0, ovf_b},       64'd0);
    endtask

    initial begin
        logic [15:0] s;
        logic        c;
        int          gap;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum_in = '0; carry_in = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_in_ready",  {63'd0, in_ready_a},  64'd1);
        chk("reset_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("reset_acc",       {44'd0, acc_a},       64'd0);
        chk("reset_ovf",       {63'd0, ovf_a},       64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back burst 1+2+3+4.
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        chk("b1_not_done", {63'd0, out_valid_a}, 64'd0);
        send(16'h0004, 1'b0);
        check_total("b1");
        chk("b1_literal", {44'd0, acc_a}, 64'h0000A);

        // Stall the sink for 5 cycles while the source keeps offering data.
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            sum_in   = 16'hFFFF;
            carry_in = 1'b1;
            @(negedge clk);
            chk("stall_acc",       {44'd0, acc_a},       64'h0000A);
            chk("stall_out_valid", {63'd0, out_valid_a}, 64'd1);
            chk("stall_in_ready",  {63'd0, in_ready_a},  64'd0);
        end
        in_valid = 1'b0;
        accept("stall");

        // Max operands: fits in 20 bits, overflows 18 bits.
        for (int i = 0; i < 4; i++) send(16'hFFFF, 1'b1);
        check_total("max");
        chk("max_acc_a_lit", {44'd0, acc_a}, 64'h7FFFC);
        chk("max_ovf_a_lit", {63'd0, ovf_a}, 64'd0);
        chk("max_ovf_b_lit", {63'd0, ovf_b}, 64'd1);
`ifdef SATURATE_EN
        chk("max_acc_b_lit", {46'd0, acc_b}, 64'h3FFFF);
`else
        chk("max_acc_b_lit", {46'd0, acc_b}, 64'h3FFFC);
`endif
        accept("max");

        // Clear mid-burst with a competing input transfer.
        send(16'h1234, 1'b0);
        send(16'h0F00, 1'b1);
        clr = 1'b1; in_valid = 1'b1; sum_in = 16'h5555; carry_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        model_clear();
        chk("clr_acc",       {44'd0, acc_a},       64'd0);
        chk("clr_in_ready",  {63'd0, in_ready_a},  64'd1);
        chk("clr_out_valid", {63'd0, out_valid_a}, 64'd0);
        for (int i = 0; i < 3; i++) send(16'h0001, 1'b0);
        chk("clr_cnt_reset", {63'd0, out_valid_a}, 64'd0);
        send(16'h0001, 1'b0);
        check_total("post_clr");
        chk("post_clr_lit", {44'd0, acc_a}, 64'h00004);
        accept("post_clr");

        // Asynchronous reset between clock edges.
        send(16'h8000, 1'b1);
        send(16'h0123, 1'b0);
        chk("pre_rst_acc", {44'd0, acc_a}, 64'(m_acc[0]));
        #2 rst = 1'b1;
        #1;
        chk("arst_acc",       {44'd0, acc_a},       64'd0);
        chk("arst_in_ready",  {63'd0, in_ready_a},  64'd1);
        chk("arst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("arst_ovf",       {63'd0, ovf_a},       64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);

        // Randomized bursts with gaps and sink stalls.
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < COUNT; i++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
                chk("rnd_no_early_done", {63'd0, out_valid_a}, 64'd0);
                s = 16'($urandom);
                c = 1'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    s = 16'($urandom_range(0, 255));
                    c = 1'b0;
                end
                send(s, c);
            end
            check_total("rnd");
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                chk("rnd_hold_acc_b", {46'd0, acc_b}, 64'(m_acc[1]));
            end
            accept("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
